// File: rtl/fetch_pkg.sv
// Shared types and constants for the ROM instruction-fetch sequencer.
package fetch_pkg;

  localparam int FETCH_AW = 8;
  localparam int FETCH_DW = 16;

  localparam logic [15:0] HALT_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect load beats capture increment; otherwise holds.
// Single-cycle update, async reset to RESET_PC.
module fetch_pc_reg #(
  parameter int             AW       = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] pc
);

  // Increment wraps naturally at the top of the address space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + AW'(1);
    end
  end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// ROM fetch sequencer: one-entry instruction slot, first word valid one edge after entering FETCH,
// one word/cycle; slot holds under !instr_ready. FETCH_HALT_DETECT_EN enables halt on the all-zero word.
module rom_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int            AW       = FETCH_AW,
  parameter int            DW       = FETCH_DW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          busy,
  output logic          halted
);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [AW-1:0] pc;
  logic          slot_free;
  logic          halt_hit;
  logic          capture;

  assign slot_free = !instr_valid || instr_ready;

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = (rom_data == DW'(HALT_WORD));
`else
  assign halt_hit = 1'b0;
`endif

  // Redirect always wins: no capture in the cycle the PC is being reloaded.
  assign capture = (state == FETCH) && !redirect && slot_free && !halt_hit;

  fetch_pc_reg #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (redirect),
    .load_val (redirect_pc),
    .inc      (capture),
    .pc       (pc)
  );

  assign rom_addr = pc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (!redirect && slot_free && halt_hit) state_nxt = HALT;
      HALT:    if (redirect) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (capture) begin
      instr    <= rom_data;
      instr_pc <= pc;
    end
  end

  // A handshake coinciding with redirect or halt is still consumed; the slot just empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (capture) begin
      instr_valid <= 1'b1;
    end else if (instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

  assign busy = (state == FETCH);

`ifdef FETCH_HALT_DETECT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
